// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard sequencer: FSM state encoding, hazard need codes
// and the register-match helper used by the hazard detector.
package hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_STALL2 = 1'b1
    } hz_state_e;

    typedef enum logic [1:0] {
        NEED_NONE = 2'd0,
        NEED_ONE  = 2'd1,
        NEED_TWO  = 2'd2
    } hz_need_e;

    // A producer register conflicts with the ID instruction when it is not $0
    // and equals rs, or equals rt while the ID instruction actually reads rt.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset/clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use and ID-branch operand stalls, taken-branch
// IF_ID flush, whole-pipe freeze while data memory is busy, and saturating
// stall/flush performance counters. Control outputs are combinational from
// the current state and inputs. state_dbg_o exposes the FSM state.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS,
    input  logic [4:0]       IF_ID_RT,
    input  logic             ID_uses_rt,
    input  logic             ID_branch,
    input  logic             ID_branch_taken,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_regwrite,
    input  logic             ID_EX_memread,
    input  logic [4:0]       EX_MEM_RD,
    input  logic             EX_MEM_memread,
    input  logic             dmem_busy_i,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output hz_state_e        state_dbg_o
);

    hz_state_e state_q;
    hz_state_e state_d;
    hz_need_e  need;
    logic      ex_hit;
    logic      mem_hit;
    logic      stall_inc;
    logic      flush_inc;

    // Hazard need: stall cycles the current ID instruction requires.
    always_comb begin
        ex_hit  = reg_match(ID_EX_RD,  IF_ID_RS, IF_ID_RT, ID_uses_rt);
        mem_hit = reg_match(EX_MEM_RD, IF_ID_RS, IF_ID_RT, ID_uses_rt);
        need    = NEED_NONE;
        if (ID_EX_memread && ex_hit) begin
            need = ID_branch ? NEED_TWO : NEED_ONE;
        end else if (ID_branch && ID_EX_regwrite && ex_hit) begin
            need = NEED_ONE;
        end else if (ID_branch && EX_MEM_memread && mem_hit) begin
            need = NEED_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: busy freezes the FSM; STALL2 always returns to RUN.
    always_comb begin
        state_d = state_q;
        if (!dmem_busy_i) begin
            if (state_q == ST_STALL2) begin
                state_d = ST_RUN;
            end else if (need == NEED_TWO) begin
                state_d = ST_STALL2;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // Pipeline control outputs and counter increments, in priority order.
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_freeze = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (rst_i) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
        end else if (dmem_busy_i) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_freeze = 1'b1;
            stall_inc   = 1'b1;
        end else if ((state_q == ST_STALL2) || (need != NEED_NONE)) begin
            // A stall beats a taken branch: the branch re-resolves later.
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            stall_inc   = 1'b1;
        end else if (ID_branch && ID_branch_taken) begin
            IF_ID_flush = 1'b1;
            flush_inc   = 1'b1;
        end
    end

    assign state_dbg_o = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule
